// File: rtl/window_scheduler.sv
// Sequences a raster pixel stream into a sliding-window line buffer and flags
// only windows that lie fully inside the current frame.
module window_scheduler #(
  parameter int unsigned dataWidth    = 1,
  parameter int unsigned kernelWidth  = 2,
  parameter int unsigned kernelHeight = 2,
  parameter int unsigned imageWidth   = 256,
  parameter int unsigned imageHeight  = 256
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic [dataWidth-1:0]           i_pixel_data,
  input  logic                           i_pixel_valid,
  output logic                           o_pixel_ready,
  output logic [dataWidth-1:0]           o_buf_pixel_data,
  output logic                           o_buf_pixel_valid,
  output logic                           o_window_valid,
  input  logic                           i_window_ready,
  output logic [$clog2(imageWidth)-1:0]  o_col,
  output logic [$clog2(imageHeight)-1:0] o_row,
  output logic                           o_busy,
  output logic                           o_frame_done
);

  localparam int unsigned ColW = $clog2(imageWidth);
  localparam int unsigned RowW = $clog2(imageHeight);

  localparam logic [ColW-1:0] ColLast     = ColW'(imageWidth - 1);
  localparam logic [RowW-1:0] RowLast     = RowW'(imageHeight - 1);
  localparam logic [RowW-1:0] RowFillLast = RowW'((kernelHeight > 1) ? kernelHeight - 2 : 0);

  typedef enum logic [1:0] {StIdle, StFill, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            win_valid_q, win_valid_d;
  logic [ColW-1:0] win_col_q, win_col_d;
  logic [RowW-1:0] win_row_q, win_row_d;

  logic pixel_ready, acc, col_last, qualifies, frame_done;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = win_valid_q;
    win_col_d   = win_col_q;
    win_row_d   = win_row_q;

    // Hold the buffer whenever an unconsumed window is still being presented.
    pixel_ready = ((state_q == StFill) || (state_q == StRun)) && (!win_valid_q || i_window_ready);
    acc         = i_pixel_valid && pixel_ready;
    col_last    = (col_q == ColLast);
    qualifies   = (int'(col_q) >= int'(kernelWidth) - 1) &&
                  (int'(row_q) >= int'(kernelHeight) - 1);
    frame_done  = (state_q == StDrain) && win_valid_q && i_window_ready;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          col_d   = '0;
          row_d   = '0;
          state_d = (kernelHeight == 1) ? StRun : StFill;
        end
      end
      StFill:  if (acc && col_last && (row_q == RowFillLast)) state_d = StRun;
      StRun:   if (acc && col_last && (row_q == RowLast)) state_d = StDrain;
      StDrain: if (frame_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (acc) begin
      if (col_last) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // A new accept overwrites the presented window on the same edge it retires.
    if (acc) begin
      win_valid_d = qualifies;
      win_col_d   = col_q;
      win_row_d   = row_q;
    end else if (i_window_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_col_q   <= win_col_d;
      win_row_q   <= win_row_d;
    end
  end

  assign o_pixel_ready     = pixel_ready;
  assign o_buf_pixel_data  = i_pixel_data;
  assign o_buf_pixel_valid = acc;
  assign o_window_valid    = win_valid_q;
  assign o_col             = win_col_q;
  assign o_row             = win_row_q;
  assign o_busy            = (state_q != StIdle);
  assign o_frame_done      = frame_done;

endmodule

// File: tb/tb_window_scheduler.sv
// Directed bench for window_scheduler on a 4x3 image: 2x2 kernel instance plus a 1x1 instance.
module tb_window_scheduler;

  localparam int W = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, pix_valid, win_ready;
  logic [7:0] pix_data;
  logic       o_pixel_ready, o_buf_pixel_valid, o_window_valid, o_busy, o_frame_done;
  logic [7:0] o_buf_pixel_data;
  logic [1:0] o_col, o_row;

  logic       start1, pix_valid1;
  logic [7:0] pix_data1;
  logic       ready1, bvalid1, wvalid1, busy1, done1;
  logic [7:0] bdata1;
  logic [1:0] col1, row1;

  window_scheduler #(.dataWidth(8), .kernelWidth(2), .kernelHeight(2),
                     .imageWidth(W), .imageHeight(H)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pixel_data(pix_data),
    .i_pixel_valid(pix_valid), .o_pixel_ready(o_pixel_ready),
    .o_buf_pixel_data(o_buf_pixel_data), .o_buf_pixel_valid(o_buf_pixel_valid),
    .o_window_valid(o_window_valid), .i_window_ready(win_ready), .o_col(o_col),
    .o_row(o_row), .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  window_scheduler #(.dataWidth(8), .kernelWidth(1), .kernelHeight(1),
                     .imageWidth(W), .imageHeight(H)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_pixel_data(pix_data1),
    .i_pixel_valid(pix_valid1), .o_pixel_ready(ready1),
    .o_buf_pixel_data(bdata1), .o_buf_pixel_valid(bvalid1),
    .o_window_valid(wvalid1), .i_window_ready(1'b1), .o_col(col1),
    .o_row(row1), .o_busy(busy1), .o_frame_done(done1)
  );

  int checks = 0;
  int failures = 0;

  int exp_col [6] = '{1, 2, 3, 1, 2, 3};
  int exp_row [6] = '{1, 1, 1, 2, 2, 2};

  // Monitor: windows retired and pixels shifted, sampled mid-cycle.
  int         win_c[$];
  int         win_r[$];
  logic [31:0] win_d[$];
  logic [7:0] hist[$];
  int         done_cnt, done_at;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_window_valid && win_ready) begin
        int n;
        n = hist.size();
        win_c.push_back(int'(o_col));
        win_r.push_back(int'(o_row));
        if (n >= W + 2) win_d.push_back({hist[n-2-W], hist[n-1-W], hist[n-2], hist[n-1]});
        else            win_d.push_back(32'h0);
      end
      if (o_frame_done) begin
        done_cnt++;
        done_at = win_c.size();
      end
      if (o_buf_pixel_valid) hist.push_back(o_buf_pixel_data);
    end
  end

  task automatic clear_mon();
    win_c.delete(); win_r.delete(); win_d.delete(); hist.delete();
    done_cnt = 0;
    done_at  = -1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int first, input int last, input bit gaps, output bit to);
    to = 1'b0;
    for (int p = first; p <= last; p++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        pix_valid = 1'b0;
        @(posedge clk); #1;
      end
      pix_valid = 1'b1;
      pix_data  = 8'(p);
      begin
        int guard;
        for (guard = 0; guard < 50; guard++) begin
          @(negedge clk);
          if (o_pixel_ready) break;
        end
        if (guard == 50) to = 1'b1;
      end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(output bit to);
    int guard;
    to = 1'b0;
    for (guard = 0; guard < 100; guard++) begin
      @(negedge clk);
      if (o_frame_done) break;
    end
    if (guard == 100) to = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b1;
    start1 = 1'b0; pix_valid1 = 1'b0; pix_data1 = '0;
    #12;
    checks++; if (o_pixel_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", o_pixel_ready); end
    checks++; if (o_buf_pixel_valid !== 1'b0) begin failures++; $display("FAIL reset_bvalid got=%b exp=0", o_buf_pixel_valid); end
    checks++; if (o_window_valid !== 1'b0) begin failures++; $display("FAIL reset_wvalid got=%b exp=0", o_window_valid); end
    checks++; if (o_col !== 2'd0 || o_row !== 2'd0) begin failures++; $display("FAIL reset_colrow got=%0d,%0d exp=0,0", o_col, o_row); end
    checks++; if (o_busy !== 1'b0 || o_frame_done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", o_busy, o_frame_done); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_busy !== 1'b0 || o_pixel_ready !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy=%b ready=%b exp=0,0", o_busy, o_pixel_ready); end
  endtask

  task automatic test_full_frame();
    bit to;
    clear_mon();
    start_frame();
    checks++; if (o_busy !== 1'b1 || o_pixel_ready !== 1'b1) begin failures++; $display("FAIL start_ready busy=%b ready=%b exp=1,1", o_busy, o_pixel_ready); end
    feed(1, 12, 1'b0, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL full_feed_timeout got=%b exp=0", to); end
    wait_done(to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL full_done_timeout got=%b exp=0", to); end
    checks++; if (win_c.size() != 6) begin failures++; $display("FAIL full_count got=%0d exp=6", win_c.size()); end
    for (int i = 0; i < 6 && i < win_c.size(); i++) begin
      checks++;
      if (win_c[i] != exp_col[i] || win_r[i] != exp_row[i]) begin
        failures++; $display("FAIL full_coord[%0d] got=%0d,%0d exp=%0d,%0d", i, win_c[i], win_r[i], exp_col[i], exp_row[i]);
      end
    end
    if (win_d.size() > 0) begin
      checks++; if (win_d[0] !== {8'd1, 8'd2, 8'd5, 8'd6}) begin failures++; $display("FAIL full_win0 got=%h exp=01020506", win_d[0]); end
    end
    checks++; if (done_cnt != 1 || done_at != 6) begin failures++; $display("FAIL full_done cnt=%0d at=%0d exp=1,6", done_cnt, done_at); end
    checks++; if (o_busy !== 1'b0 || o_window_valid !== 1'b0) begin failures++; $display("FAIL full_idle busy=%b wvalid=%b exp=0,0", o_busy, o_window_valid); end
    checks++; if (hist.size() != 12) begin failures++; $display("FAIL full_shifts got=%0d exp=12", hist.size()); end
  endtask

  task automatic test_edge_masking();
    bit to;
    clear_mon();
    start_frame();
    for (int p = 1; p <= 12; p++) begin
      bit q;
      pix_valid = 1'b1;
      pix_data  = 8'(p);
      @(posedge clk); #1;
      q = (((p - 1) % W) >= 1) && (((p - 1) / W) >= 1);
      checks++;
      if (o_window_valid !== q) begin failures++; $display("FAIL mask_pix%0d got=%b exp=%b", p, o_window_valid, q); end
    end
    pix_valid = 1'b0;
    wait_done(to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL mask_done_timeout got=%b exp=0", to); end
    foreach (win_d[i]) begin
      checks++;
      if (win_d[i] === {8'd4, 8'd5, 8'd8, 8'd9}) begin failures++; $display("FAIL mask_wrapped got=%h exp=not 04050809", win_d[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_mon();
    start_frame();
    feed(1, 7, 1'b0, to);
    win_ready = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 8'd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (o_pixel_ready !== 1'b0 || o_buf_pixel_valid !== 1'b0) begin
        failures++; $display("FAIL bp_stall%0d ready=%b bvalid=%b exp=0,0", i, o_pixel_ready, o_buf_pixel_valid);
      end
      checks++;
      if (o_window_valid !== 1'b1 || o_col !== 2'd2 || o_row !== 2'd1) begin
        failures++; $display("FAIL bp_hold%0d wv=%b col=%0d row=%0d exp=1,2,1", i, o_window_valid, o_col, o_row);
      end
      @(posedge clk); #1;
    end
    win_ready = 1'b1;
    #1;
    checks++; if (o_pixel_ready !== 1'b1 || o_buf_pixel_valid !== 1'b1) begin failures++; $display("FAIL bp_release ready=%b bvalid=%b exp=1,1", o_pixel_ready, o_buf_pixel_valid); end
    @(posedge clk); #1;
    checks++; if (o_col !== 2'd3 || o_row !== 2'd1) begin failures++; $display("FAIL bp_next col=%0d row=%0d exp=3,1", o_col, o_row); end
    pix_valid = 1'b0;
    feed(9, 12, 1'b0, to);
    wait_done(to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL bp_done_timeout got=%b exp=0", to); end
    checks++; if (win_c.size() != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", win_c.size()); end
  endtask

  task automatic test_source_gaps();
    bit to, to2;
    clear_mon();
    start_frame();
    feed(1, 12, 1'b1, to);
    wait_done(to2);
    checks++; if (to !== 1'b0 || to2 !== 1'b0) begin failures++; $display("FAIL gap_timeout got=%b%b exp=00", to, to2); end
    checks++; if (win_c.size() != 6 || hist.size() != 12) begin failures++; $display("FAIL gap_counts win=%0d shifts=%0d exp=6,12", win_c.size(), hist.size()); end
    for (int i = 0; i < 6 && i < win_c.size(); i++) begin
      checks++;
      if (win_c[i] != exp_col[i] || win_r[i] != exp_row[i]) begin
        failures++; $display("FAIL gap_coord[%0d] got=%0d,%0d exp=%0d,%0d", i, win_c[i], win_r[i], exp_col[i], exp_row[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    clear_mon();
    start_frame();
    feed(1, 7, 1'b0, to);
    rst_n = 1'b0;
    #1;
    checks++; if (o_window_valid !== 1'b0 || o_col !== 2'd0 || o_row !== 2'd0) begin failures++; $display("FAIL rst_mid_win wv=%b col=%0d row=%0d exp=0,0,0", o_window_valid, o_col, o_row); end
    checks++; if (o_busy !== 1'b0 || o_pixel_ready !== 1'b0 || o_frame_done !== 1'b0) begin failures++; $display("FAIL rst_mid_ctl busy=%b ready=%b done=%b exp=000", o_busy, o_pixel_ready, o_frame_done); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    start_frame();
    feed(1, 5, 1'b0, to);
    checks++; if (o_window_valid !== 1'b0 || win_c.size() != 0) begin failures++; $display("FAIL rst_early wv=%b wins=%0d exp=0,0", o_window_valid, win_c.size()); end
    feed(6, 12, 1'b0, to);
    wait_done(to);
    checks++; if (to !== 1'b0 || win_c.size() != 6) begin failures++; $display("FAIL rst_frame to=%b wins=%0d exp=0,6", to, win_c.size()); end
    if (win_c.size() > 0) begin
      checks++;
      if (win_c[0] != 1 || win_r[0] != 1 || win_d[0] !== {8'd1, 8'd2, 8'd5, 8'd6}) begin
        failures++; $display("FAIL rst_first got=%0d,%0d %h exp=1,1 01020506", win_c[0], win_r[0], win_d[0]);
      end
    end
  endtask

  task automatic test_degenerate();
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int p = 1; p <= 12; p++) begin
      pix_valid1 = 1'b1;
      pix_data1  = 8'(p);
      @(posedge clk); #1;
      checks++;
      if (wvalid1 !== 1'b1 || int'(col1) != (p - 1) % W || int'(row1) != (p - 1) / W || done1 !== (p == 12)) begin
        failures++; $display("FAIL deg_pix%0d wv=%b col=%0d row=%0d done=%b exp=1,%0d,%0d,%b",
                             p, wvalid1, col1, row1, done1, (p - 1) % W, (p - 1) / W, p == 12);
      end
    end
    pix_valid1 = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy1 !== 1'b0 || wvalid1 !== 1'b0) begin failures++; $display("FAIL deg_idle busy=%b wv=%b exp=0,0", busy1, wvalid1); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_edge_masking();
    test_backpressure();
    test_source_gaps();
    test_reset_mid_frame();
    test_degenerate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
